// File: rtl/acc_shift_seq_pkg.sv
// Shared definitions for the accumulator load/store sequencer: opcodes,
// FSM state encoding and the legal parallel-shift set for stores.
package acc_shift_seq_pkg;

  localparam logic [1:0] OP_LAC  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_SACH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EXEC = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // The parallel shifter only supports shifts of 0, 1 and 4.
  function automatic logic legal_pshift(input logic [3:0] sh);
    return (sh == 4'd0) || (sh == 4'd1) || (sh == 4'd4);
  endfunction

endpackage

// File: rtl/acc_shift_seq_shift.sv
// Datapath shifters: barrel (16-bit signed operand scaled into 32 bits) and
// parallel (upper half of the accumulator after a 0/1/4 left shift).
module acc_shift_seq_barrel (
  input  logic [15:0] din,
  input  logic [3:0]  sh,
  output logic [31:0] dout
);
  logic [31:0] w_ext;

  assign w_ext = {{16{din[15]}}, din};
  assign dout  = w_ext << sh;
endmodule

module acc_shift_seq_parallel (
  input  logic [31:0] acc_in,
  input  logic [2:0]  sh,
  output logic [15:0] dout
);
  always_comb begin
    dout = acc_in[31:16];
    case (sh)
      3'd1:    dout = acc_in[30:15];
      3'd4:    dout = acc_in[27:12];
      default: dout = acc_in[31:16];
    endcase
  end
endmodule

// File: rtl/acc_shift_seq.sv
// Accumulator sequencer: runs one LAC/ADD/SUB/SACH at a time against a
// single-port RAM over a req/ack handshake; all outputs are registered.
module acc_shift_seq
  import acc_shift_seq_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  // Command: accepted on the rising edge where cmd_valid & cmd_ready are both high.
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [3:0]    cmd_shift,
  output logic          mem_rd_req,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [31:0]   acc,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  state_t        r_state;
  logic [1:0]    r_op;
  logic [3:0]    r_shift;
  logic [15:0]   r_rdata;
  logic [31:0]   r_acc;
  logic          r_ovf, r_rd_req, r_wr_req, r_done, r_err, r_busy, r_ready;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_wdata;

  logic [31:0]   w_b, w_sum, w_diff;
  logic [15:0]   w_par;

  acc_shift_seq_barrel u_barrel (
    .din  (r_rdata),
    .sh   (r_shift),
    .dout (w_b)
  );

  // Store data comes from the accumulator as it stands at accept time.
  acc_shift_seq_parallel u_parallel (
    .acc_in (r_acc),
    .sh     (cmd_shift[2:0]),
    .dout   (w_par)
  );

  assign w_sum  = r_acc + w_b;
  assign w_diff = r_acc - w_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_LAC;
      r_shift    <= '0;
      r_rdata    <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_shift <= cmd_shift;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (cmd_op != OP_SACH) begin
              r_state    <= S_RD;
              r_rd_req   <= 1'b1;
              r_mem_addr <= cmd_addr;
            end else if (legal_pshift(cmd_shift)) begin
              r_state    <= S_WR;
              r_wr_req   <= 1'b1;
              r_mem_addr <= cmd_addr;
              r_wdata    <= w_par;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            r_rdata  <= mem_rdata;
            r_rd_req <= 1'b0;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Signed overflow is sticky until the next LAC.
          case (r_op)
            OP_LAC: begin
              r_acc <= w_b;
              r_ovf <= 1'b0;
            end
            OP_ADD: begin
              r_acc <= w_sum;
              if ((r_acc[31] == w_b[31]) && (w_sum[31] != r_acc[31])) r_ovf <= 1'b1;
            end
            OP_SUB: begin
              r_acc <= w_diff;
              if ((r_acc[31] != w_b[31]) && (w_diff[31] != r_acc[31])) r_ovf <= 1'b1;
            end
            default: r_acc <= r_acc;
          endcase
          r_state <= S_FIN;
          r_done  <= 1'b1;
        end
        S_WR: begin
          if (mem_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= S_FIN;
            r_done   <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_req <= 1'b0;
          r_wr_req <= 1'b0;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_ready;
  assign mem_rd_req = r_rd_req;
  assign mem_wr_req = r_wr_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_wdata;
  assign acc        = r_acc;
  assign ovf        = r_ovf;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_acc_shift_seq.sv
// Bench for acc_shift_seq: RAM responder with programmable ack delay,
// accumulator reference model and scoreboard queues popped at done.
module tb_acc_shift_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_addr = 8'h00;
  logic [3:0]  cmd_shift = 4'h0;
  logic        mem_rd_req, mem_wr_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [31:0] acc;
  logic        ovf, busy, done, err;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [256];
  logic [31:0] m_acc = 32'h0;
  logic        m_ovf = 1'b0;

  logic [31:0] exp_acc_q [$];
  logic [0:0]  exp_ovf_q [$];
  logic [0:0]  exp_err_q [$];
  logic [15:0] exp_wd_q  [$];

  always #5 clk = ~clk;

  acc_shift_seq #(.AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_shift  (cmd_shift),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .acc        (acc),
    .ovf        (ovf),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  function automatic logic [31:0] bext(input logic [15:0] d, input logic [3:0] sh);
    logic [31:0] e;
    e = {{16{d[15]}}, d};
    return e << sh;
  endfunction

  // Driver + scoreboard: model pushes expectations at issue, pops at completion.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] sh,
                         input int dly, input bit poke);
    logic [31:0] b, r, e_acc;
    logic [15:0] e_wd;
    logic [0:0]  e_ovf, e_err;
    bit          is_ld, legal;
    is_ld = (op != 2'b11);
    legal = is_ld || (sh == 4'd0) || (sh == 4'd1) || (sh == 4'd4);
    if (is_ld) begin
      b = bext(ram[addr], sh);
      case (op)
        2'b00: begin m_acc = b; m_ovf = 1'b0; end
        2'b01: begin
          r = m_acc + b;
          if (m_acc[31] == b[31] && r[31] != m_acc[31]) m_ovf = 1'b1;
          m_acc = r;
        end
        default: begin
          r = m_acc - b;
          if (m_acc[31] != b[31] && r[31] != m_acc[31]) m_ovf = 1'b1;
          m_acc = r;
        end
      endcase
    end else if (legal) begin
      e_wd = (sh == 4'd0) ? m_acc[31:16] : (sh == 4'd1) ? m_acc[30:15] : m_acc[27:12];
      exp_wd_q.push_back(e_wd);
    end
    exp_acc_q.push_back(m_acc);
    exp_ovf_q.push_back(m_ovf);
    exp_err_q.push_back(legal ? 1'b0 : 1'b1);

    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_shift = sh;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_shift = 4'($urandom);

    if (legal) begin
      checks++;
      if ({mem_rd_req, mem_wr_req} !== (is_ld ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL req_start: got %b want %b", {mem_rd_req, mem_wr_req}, is_ld ? 2'b10 : 2'b01);
      end
      checks++;
      if (mem_addr !== addr) begin errors++; $display("FAIL mem_addr: got %h want %h", mem_addr, addr); end
      if (!is_ld) begin
        e_wd = exp_wd_q.pop_front();
        checks++;
        if (mem_wdata !== e_wd) begin errors++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, e_wd); end
      end
      for (int i = 0; i < dly; i++) begin
        if (poke) begin cmd_valid = 1'b1; cmd_op = 2'b00; end
        @(posedge clk); #1;
        checks++;
        if ({mem_rd_req, mem_wr_req, mem_addr, cmd_ready, busy} !== {is_ld, !is_ld, addr, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL hold: got rd=%b wr=%b addr=%h rdy=%b busy=%b want rd=%b wr=%b addr=%h rdy=0 busy=1",
                   mem_rd_req, mem_wr_req, mem_addr, cmd_ready, busy, is_ld, !is_ld, addr);
        end
      end
      cmd_valid = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = ram[addr];
      if (!is_ld) ram[addr] = mem_wdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      if (is_ld) begin
        checks++;
        if ({done, mem_rd_req} !== 2'b00) begin
          errors++; $display("FAIL exec_cycle: got done=%b rd=%b want 0 0", done, mem_rd_req);
        end
        @(posedge clk); #1;
      end
    end

    e_acc = exp_acc_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    e_err = exp_err_q.pop_front();
    checks++;
    if ({done, err, mem_rd_req, mem_wr_req} !== {1'b1, e_err, 2'b00}) begin
      errors++; $display("FAIL fin_flags: got done=%b err=%b rd=%b wr=%b want 1 %b 0 0", done, err, mem_rd_req, mem_wr_req, e_err);
    end
    checks++;
    if (acc !== e_acc) begin errors++; $display("FAIL acc: got %h want %h", acc, e_acc); end
    checks++;
    if (ovf !== e_ovf) begin errors++; $display("FAIL ovf: got %b want %b", ovf, e_ovf); end
    @(posedge clk); #1;
    checks++;
    if ({done, err, cmd_ready, busy} !== 4'b0010) begin
      errors++; $display("FAIL after_fin: got done=%b err=%b rdy=%b busy=%b want 0 0 1 0", done, err, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({acc, ovf, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, done, err, busy, cmd_ready, dbg_state} !==
        {32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: got acc=%h ovf=%b rd=%b wr=%b addr=%h wd=%h done=%b err=%b busy=%b rdy=%b st=%0d",
               acc, ovf, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, done, err, busy, cmd_ready, dbg_state);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lac();
    ram[8'h10] = 16'h8001;
    run_cmd(2'b00, 8'h10, 4'd4, 0, 1'b0);
    checks++;
    if ({acc, ovf} !== {32'hFFF8_0010, 1'b0}) begin errors++; $display("FAIL lac_const: got %h/%b want fff80010/0", acc, ovf); end
  endtask

  task automatic test_add_sub_ovf();
    ram[8'h20] = 16'h7FFF;
    run_cmd(2'b00, 8'h20, 4'd15, 0, 1'b0);
    checks++;
    if (acc !== 32'h3FFF_8000) begin errors++; $display("FAIL lac15: got %h want 3fff8000", acc); end
    run_cmd(2'b01, 8'h20, 4'd15, 0, 1'b0);
    checks++;
    if ({acc, ovf} !== {32'h7FFF_0000, 1'b0}) begin errors++; $display("FAIL add1: got %h/%b want 7fff0000/0", acc, ovf); end
    run_cmd(2'b01, 8'h20, 4'd15, 0, 1'b0);
    checks++;
    if ({acc, ovf} !== {32'hBFFE_8000, 1'b1}) begin errors++; $display("FAIL add2: got %h/%b want bffe8000/1", acc, ovf); end
    run_cmd(2'b10, 8'h20, 4'd15, 0, 1'b0);
    checks++;
    if ({acc, ovf} !== {32'h7FFF_0000, 1'b1}) begin errors++; $display("FAIL sub: got %h/%b want 7fff0000/1", acc, ovf); end
    run_cmd(2'b00, 8'h20, 4'd0, 0, 1'b0);
    checks++;
    if ({acc, ovf} !== {32'h0000_7FFF, 1'b0}) begin errors++; $display("FAIL lac_clr: got %h/%b want 00007fff/0", acc, ovf); end
  endtask

  task automatic test_sach();
    ram[8'h30] = 16'h2468;
    ram[8'h31] = 16'h5678;
    run_cmd(2'b00, 8'h30, 4'd15, 0, 1'b0);
    run_cmd(2'b01, 8'h31, 4'd0, 0, 1'b0);
    checks++;
    if (acc !== 32'h1234_5678) begin errors++; $display("FAIL sach_setup: got %h want 12345678", acc); end
    run_cmd(2'b11, 8'h40, 4'd1, 0, 1'b0);
    run_cmd(2'b11, 8'h41, 4'd4, 1, 1'b0);
    run_cmd(2'b11, 8'h42, 4'd0, 0, 1'b0);
    checks++;
    if ({ram[8'h40], ram[8'h41], ram[8'h42]} !== {16'h2468, 16'h2345, 16'h1234}) begin
      errors++; $display("FAIL sach_data: got %h %h %h want 2468 2345 1234", ram[8'h40], ram[8'h41], ram[8'h42]);
    end
  endtask

  task automatic test_sach_illegal();
    run_cmd(2'b11, 8'h50, 4'd2, 0, 1'b0);
    run_cmd(2'b11, 8'h51, 4'd9, 0, 1'b0);
    checks++;
    if (acc !== 32'h1234_5678) begin errors++; $display("FAIL illegal_acc: got %h want 12345678", acc); end
  endtask

  task automatic test_ack_delay();
    ram[8'h60] = 16'hFFFF;
    run_cmd(2'b00, 8'h60, 4'd3, 3, 1'b1);
    run_cmd(2'b10, 8'h60, 4'd1, 2, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if ({dbg_state, busy, done, mem_rd_req, acc} !== {3'd0, 1'b0, 1'b0, 1'b0, m_acc}) begin
      errors++; $display("FAIL stray_ack: got st=%0d busy=%b done=%b rd=%b acc=%h want 0 0 0 0 %h",
                         dbg_state, busy, done, mem_rd_req, acc, m_acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [3:0] sh;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      sh = 4'($urandom_range(0, 15));
      if (op == 2'b11 && $urandom_range(0, 3) != 0) sh = (sh[0]) ? 4'd1 : (sh[1] ? 4'd4 : 4'd0);
      run_cmd(op, 8'($urandom_range(0, 255)), sh, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_in_wr();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 8'h77; cmd_shift = 4'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (mem_wr_req !== 1'b1) begin errors++; $display("FAIL wr_before_rst: got %b want 1", mem_wr_req); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_wr_req, acc, busy, cmd_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL async_rst: got wr=%b acc=%h busy=%b rdy=%b want 0 0 0 1", mem_wr_req, acc, busy, cmd_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_acc = 32'h0; m_ovf = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, done, mem_wr_req} !== 3'b100) begin
      errors++; $display("FAIL post_rst: got rdy=%b done=%b wr=%b want 1 0 0", cmd_ready, done, mem_wr_req);
    end
    ram[8'h78] = 16'h0003;
    run_cmd(2'b01, 8'h78, 4'd2, 1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    test_reset();
    test_lac();
    test_add_sub_ovf();
    test_sach();
    test_sach_illegal();
    test_ack_delay();
    test_back_to_back();
    test_reset_in_wr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
